trig_acq_ctrl: RTL



---
 rtl/osc_pkg.sv | 27 ++
 rtl/trig_detect.sv | 45 ++++
 rtl/trig_acq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// Shared types for the acquisition/trigger sequencer: FSM state encoding,
// capture mode codes and default datapath widths.
package osc_pkg;

  localparam int DW_DEF = 12;
  localparam int AW_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } acq_state_t;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_SINGLE = 2'd2
  } acq_mode_t;

  // Code 3 is not a distinct mode; it behaves as normal.
  function automatic acq_mode_t norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_NORMAL : acq_mode_t'(m);
  endfunction

endpackage

// File: rtl/trig_detect.sv
// Level/slope trigger comparator on the decimated sample stream; compares each
// kept sample against the previous kept sample of the same frame.
module trig_detect
  import osc_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          keep,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  output logic          trig
);

  logic [DW-1:0] prev;
  logic          prev_vld;
  logic          rise_hit;
  logic          fall_hit;

  // prev_vld drops between frames so an edge never spans two captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
    end else if (clr) begin
      prev_vld <= 1'b0;
    end else if (keep) begin
      prev_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      prev <= x;
    end
  end

  assign rise_hit = (prev < trig_level) && (x >= trig_level);
  assign fall_hit = (prev > trig_level) && (x <= trig_level);
  assign trig     = en && keep && prev_vld && (trig_slope ? fall_hit : rise_hit);

endmodule

// File: rtl/trig_acq_ctrl.sv
// Acquisition sequencer: decimates ADC samples into a circular frame buffer,
// holds pre-trigger history, captures post-trigger data and hands off a frozen frame.
module trig_acq_ctrl
  import osc_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NSAMP    = 800,
  parameter int PRE_TRIG = 400,
  parameter int AUTO_TO  = 1 << 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic [1:0]    mode,
  input  logic          arm,
  input  logic [7:0]    decim,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [DW-1:0] buf_wdata,
  output logic          frame_ready,
  input  logic          frame_ack,
  output logic [AW-1:0] start_addr,
  output logic          auto_trig,
  output logic [2:0]    state_o
);

  localparam int TW = $clog2(AUTO_TO + 1);
  localparam int CW = $clog2(NSAMP + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NSAMP - 1);
  localparam logic [AW:0]   NS_W      = (AW+1)'(NSAMP);
  localparam logic [AW:0]   OFS_W     = (AW+1)'(NSAMP - PRE_TRIG);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LEN  = CW'(NSAMP - PRE_TRIG - 1);
  localparam logic [TW-1:0] TO_LIM    = TW'(AUTO_TO);

  acq_state_t    state;
  acq_mode_t     mode_q;
  acq_mode_t     mode_n;
  logic [7:0]    dec_cnt;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] pre_cnt;
  logic [CW-1:0] post_cnt;
  logic [TW-1:0] to_cnt;
  logic          active;
  logic          keep;
  logic          trig;
  logic          timed_out;
  logic          fire;

  // Oldest frame address: trigger address minus the pre-trigger depth, modulo NSAMP.
  function automatic logic [AW-1:0] back_off(input logic [AW-1:0] a);
    logic [AW:0] t;
    t = {1'b0, a} + OFS_W;
    if (t >= NS_W) t = t - NS_W;
    return t[AW-1:0];
  endfunction

  assign mode_n    = norm_mode(mode);
  assign active    = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign keep      = active && smp_valid && (dec_cnt == 8'd0);
  assign timed_out = (mode_q == MODE_AUTO) && (to_cnt == TO_LIM);
  // A genuine trigger wins over a coincident timeout.
  assign fire      = (state == ST_WAIT_TRIG) && keep && (trig || timed_out);
  assign state_o   = state;

  trig_detect #(.DW(DW)) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (!active),
    .en         (state == ST_WAIT_TRIG),
    .keep       (keep),
    .x          (smp_data),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .trig       (trig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_AUTO;
      dec_cnt     <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      to_cnt      <= '0;
      buf_we      <= 1'b0;
      buf_waddr   <= '0;
      buf_wdata   <= '0;
      frame_ready <= 1'b0;
      start_addr  <= '0;
      auto_trig   <= 1'b0;
    end else begin
      buf_we <= keep;
      if (keep) begin
        buf_waddr <= wr_ptr;
        buf_wdata <= smp_data;
        wr_ptr    <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      end

      if (!active) begin
        dec_cnt <= '0;
      end else if (smp_valid) begin
        dec_cnt <= (dec_cnt == 8'd0) ? decim : dec_cnt - 1'b1;
      end

      if ((state != ST_WAIT_TRIG) || fire) begin
        to_cnt <= '0;
      end else if ((mode_q == MODE_AUTO) && !timed_out) begin
        to_cnt <= to_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if ((mode_n != MODE_SINGLE) || arm) begin
            mode_q  <= mode_n;
            pre_cnt <= '0;
            state   <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (keep) begin
            if (pre_cnt == PRE_LAST) state <= ST_WAIT_TRIG;
            else                     pre_cnt <= pre_cnt + 1'b1;
          end
        end
        ST_WAIT_TRIG: begin
          if (fire) begin
            start_addr <= back_off(wr_ptr);
            auto_trig  <= !trig;
            post_cnt   <= POST_LEN;
            if (POST_LEN == '0) begin
              frame_ready <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (keep) begin
            if (post_cnt == CW'(1)) begin
              frame_ready <= 1'b1;
              state       <= ST_DONE;
            end else begin
              post_cnt <= post_cnt - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (frame_ack) begin
            frame_ready <= 1'b0;
            mode_q      <= mode_n;
            pre_cnt     <= '0;
            state       <= (mode_n == MODE_SINGLE) ? ST_IDLE : ST_PRE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
